led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 27000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 10, meaning the pattern step rate in Hz; DIV = CLK_HZ/TICK_HZ (integer) SHALL be >= 2.
REQ-003 The block SHALL have parameter N, default 6, legal 2..16, meaning the LED count.
REQ-004 The block SHALL have parameter PWM_BITS, default 8, legal 2..12, meaning the breathe PWM resolution.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: advance enable.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 COUNT, 01 SHIFT, 10 BREATHE, 11 HOLD.
REQ-009 The block SHALL have port led, output, N bits: registered LED pattern, active-high.
REQ-010 The block SHALL have port tick, output, 1 bit: registered one-cycle step pulse.

Function
REQ-011 The prescaler SHALL count 0..DIV-1 while en=1, wrap to 0 after DIV-1, and hold its value while en=0.
REQ-012 A step SHALL occur when prescaler=DIV-1 and en=1; tick SHALL be 1 for exactly that following cycle, in which led also shows the stepped value.
REQ-013 COUNT: the pattern SHALL increment by 1 per step, modulo 2^N (all-ones wraps to 0).
REQ-014 SHIFT: the pattern SHALL be one-hot, move one position per step, move up until bit N-1, then down until bit 0, then up again; each end value is shown for one step only.
REQ-015 BREATHE: duty (PWM_BITS wide) SHALL change by 1 per step, rising to 2^PWM_BITS-1, then falling to 0, then rising again; a free-running PWM_BITS counter advances every clk; led SHALL be all-ones when pwm_cnt < duty, else all-zeros.
REQ-016 HOLD: led, duty and direction SHALL be frozen; the prescaler and tick SHALL continue as in REQ-011/012.
REQ-017 Registered mode_q SHALL track mode; when mode != mode_q, the next edge SHALL load the entry state: COUNT led=0; SHIFT led=1, direction up; BREATHE duty=0, direction up; HOLD unchanged; and SHALL clear the prescaler. No step SHALL occur on that edge.
REQ-018 A mode change coinciding with a step SHALL give the mode change priority; the step is discarded.
REQ-019 en=0 SHALL freeze led (except BREATHE PWM output, which keeps modulating at the frozen duty) and hold tick at 0.

Reset
REQ-020 On rst=1 at a clk edge: led=0, tick=0, prescaler=0, pwm_cnt=0, duty=0, direction=up, mode_q=11 (HOLD).
REQ-021 rst SHALL override every other input, including a simultaneous step or mode change.
REQ-022 After reset with mode != HOLD, the first edge SHALL apply the REQ-017 entry initialisation.

Configuration
REQ-023 Macro LED_PATTERN_BREATHE_EN defined: BREATHE mode, the PWM counter and duty logic SHALL be compiled in per REQ-015.
REQ-024 Macro LED_PATTERN_BREATHE_EN undefined: no PWM or duty logic SHALL exist, and mode=10 SHALL behave exactly as HOLD.

Verification (CLK_HZ=100, TICK_HZ=10 -> DIV=10; N=6; PWM_BITS=3)
REQ-025 COUNT: rst for 2 cycles, mode=00, en=1 -> tick every 10 clks; led 0,1,2,...,63,0; wrap on the 64th step.
REQ-026 SHIFT: mode=01 -> led 000001,000010,...,100000,010000,...,000001; full bounce period = 10 steps.
REQ-027 Enable: in COUNT at led=5, en=0 for 37 clks -> led stays 5 and tick stays 0; after en=1, the next step completes after the remaining prescaler count (not a full 10).
REQ-028 Mode switch: COUNT at led=5 -> mode=01 -> next cycle led=000001 with no tick; first tick 10 clks later, led=000010.
REQ-029 Breathe with macro defined: mode=10, 3 steps -> duty=3; led=111111 for 3 of every 8 clks. With macro undefined, the same stimulus -> led frozen.
REQ-030 Reset mid-SHIFT at led=001000 -> next cycle led=000000 and tick=0; following cycle led=000001.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern generator with COUNT, SHIFT, BREATHE and HOLD modes.
// A prescaler divides the clock down to a step rate. Each step advances the
// pattern of the current mode, and each step is announced by a one-cycle tick.
// Optional feature: define LED_PATTERN_BREATHE_EN to compile in the BREATHE
// mode (duty ramp plus PWM). Without it, mode 2'b10 behaves exactly as HOLD.
module led_pattern_gen #(
    parameter int CLK_HZ   = 27000000,
    parameter int TICK_HZ  = 10,
    parameter int N        = 6,
    parameter int PWM_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    output logic [N-1:0] led,
    output logic         tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    // Reject parameter sets outside the legal ranges at elaboration time.
    if (DIV < 2 || N < 2 || N > 16 || PWM_BITS < 2 || PWM_BITS > 12) begin : g_param_check
        $error("led_pattern_gen: illegal parameter set");
    end

    typedef enum logic [1:0] {
        M_COUNT   = 2'b00,
        M_SHIFT   = 2'b01,
        M_BREATHE = 2'b10,
        M_HOLD    = 2'b11
    } mode_t;

    mode_t         mode_q;
    mode_t         mode_eff;
    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  led_q, led_d;
    logic          tick_q;
    logic          dir_up_q, dir_up_d;
    logic          mode_chg;
    logic          step;

`ifdef LED_PATTERN_BREATHE_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_q;
`endif

    // Map the requested mode onto the modes that exist in this build.
    always_comb begin
`ifdef LED_PATTERN_BREATHE_EN
        mode_eff = mode_t'(mode);
`else
        mode_eff = (mode == 2'b10) ? M_HOLD : mode_t'(mode);
`endif
    end

    // A mode change pre-empts any step on the same edge.
    always_comb begin
        mode_chg = (mode_eff != mode_q);
        step     = en && (presc_q == PRESC_LAST) && !mode_chg;
    end

    // Next-state logic: mode-entry initialisation, prescaler and pattern steps.
    always_comb begin
        presc_d  = presc_q;
        led_d    = led_q;
        dir_up_d = dir_up_q;
`ifdef LED_PATTERN_BREATHE_EN
        duty_d   = duty_q;
`endif
        if (mode_chg) begin
            presc_d = '0;
            case (mode_eff)
                M_COUNT: led_d = '0;
                M_SHIFT: begin
                    led_d    = N'(1);
                    dir_up_d = 1'b1;
                end
`ifdef LED_PATTERN_BREATHE_EN
                M_BREATHE: begin
                    duty_d   = '0;
                    dir_up_d = 1'b1;
                    led_d    = '0;
                end
`endif
                default: ;
            endcase
        end else begin
            if (en) begin
                presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            end
            if (step) begin
                case (mode_q)
                    M_COUNT: led_d = led_q + N'(1);
                    M_SHIFT: begin
                        // Bounce: each end position is shown for a single step.
                        if (dir_up_q) begin
                            if (led_q[N-1]) begin
                                led_d    = led_q >> 1;
                                dir_up_d = 1'b0;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d    = led_q << 1;
                                dir_up_d = 1'b1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
`ifdef LED_PATTERN_BREATHE_EN
                    M_BREATHE: begin
                        if (dir_up_q) begin
                            if (duty_q == DUTY_MAX) begin
                                duty_d   = duty_q - PWM_BITS'(1);
                                dir_up_d = 1'b0;
                            end else begin
                                duty_d = duty_q + PWM_BITS'(1);
                            end
                        end else begin
                            if (duty_q == '0) begin
                                duty_d   = duty_q + PWM_BITS'(1);
                                dir_up_d = 1'b1;
                            end else begin
                                duty_d = duty_q - PWM_BITS'(1);
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
`ifdef LED_PATTERN_BREATHE_EN
            // PWM keeps modulating even while en=0, at the (possibly frozen) duty.
            if (mode_q == M_BREATHE) begin
                led_d = (pwm_q < duty_d) ? '1 : '0;
            end
`endif
        end
    end

    // State registers with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= M_HOLD;
            presc_q  <= '0;
            led_q    <= '0;
            tick_q   <= 1'b0;
            dir_up_q <= 1'b1;
`ifdef LED_PATTERN_BREATHE_EN
            duty_q   <= '0;
            pwm_q    <= '0;
`endif
        end else begin
            mode_q   <= mode_eff;
            presc_q  <= presc_d;
            led_q    <= led_d;
            tick_q   <= step;
            dir_up_q <= dir_up_d;
`ifdef LED_PATTERN_BREATHE_EN
            duty_q   <= duty_d;
            pwm_q    <= pwm_q + PWM_BITS'(1);
`endif
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen (CLK_HZ=100, TICK_HZ=10 -> DIV=10, N=6, PWM_BITS=3).
module tb_led_pattern_gen;

    localparam int N   = 6;
    localparam int DIV = 10;
    localparam int PWM_PERIOD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] led;
    logic         tick;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CLK_HZ(100),
        .TICK_HZ(10),
        .N(N),
        .PWM_BITS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .led(led),
        .tick(tick)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (step-count based) ----------------
    int m_mode, m_k, m_presc, m_pwm, m_led, m_tick;

    function automatic int eff_mode(input logic [1:0] md);
`ifdef LED_PATTERN_BREATHE_EN
        return int'(md);
`else
        return (md == 2'b10) ? 3 : int'(md);
`endif
    endfunction

    // Bounce position after k steps: 0,1,2,3,4,5,4,3,2,1,0,...
    function automatic int shift_pos(input int k);
        int p;
        p = k % 10;
        return (p <= 5) ? p : 10 - p;
    endfunction

    // Triangle duty after k steps: 0..7..0 with period 14.
    function automatic int duty_of(input int k);
        int p;
        p = k % 14;
        return (p <= 7) ? p : 14 - p;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic [1:0] md);
        int em, pprev;
        bit stp;
        if (r) begin
            m_mode = 3; m_k = 0; m_presc = 0; m_pwm = 0; m_led = 0; m_tick = 0;
        end else begin
            em    = eff_mode(md);
            pprev = m_pwm;
            m_pwm = (m_pwm + 1) % PWM_PERIOD;
            if (em != m_mode) begin
                m_mode = em; m_presc = 0; m_tick = 0; m_k = 0;
                if (em == 0 || em == 2) m_led = 0;
                else if (em == 1) m_led = 1;
            end else begin
                stp = e && (m_presc == DIV - 1);
                if (e) m_presc = (m_presc + 1) % DIV;
                m_tick = stp ? 1 : 0;
                if (stp && em != 3) m_k++;
                if (em == 0) m_led = m_k % 64;
                else if (em == 1) m_led = 1 << shift_pos(m_k);
                else if (em == 2) m_led = (pprev < duty_of(m_k)) ? 63 : 0;
            end
        end
    endtask

    // One clock: capture driven inputs, advance DUT and model, optionally compare.
    task automatic cyc(input bit cmp);
        logic r, e;
        logic [1:0] md;
        r = rst; e = en; md = mode;
        @(posedge clk);
        #1;
        model_edge(r, e, md);
        if (cmp) begin
            check("model_led", 32'(led), 32'(m_led));
            check("model_tick", 32'(tick), 32'(m_tick));
        end
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            cyc(0);
            n++;
        end while (!tick && n < maxc);
        if (!tick) check("tick_timeout", 32'(0), 32'(1));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic         r;
        logic         e;
        logic [1:0]   md;
        logic [N-1:0] led;
        logic         tk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [1:0] md,
                       input logic [N-1:0] l, input logic tk);
        vec_t v;
        v.r = r; v.e = e; v.md = md; v.led = l; v.tk = tk;
        tbl.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ones;
        int sh[10];
        logic [N-1:0] held;
        sh = '{1, 2, 4, 8, 16, 32, 16, 8, 4, 2};
        rst = 1'b1; en = 1'b0; mode = 2'b00;

        // Reset, COUNT entry, two steps, SHIFT entry/step, en=0, reset, HOLD ticks.
        add(1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1);
        for (int i = 0; i < 9; i++) add(0, 1, 0, 1, 0);
        add(0, 1, 0, 2, 1);
        add(0, 1, 1, 1, 0);
        for (int i = 0; i < 9; i++) add(0, 1, 1, 1, 0);
        add(0, 1, 1, 2, 1);
        add(0, 0, 1, 2, 0);
        add(1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 3, 1, 0);
        for (int i = 0; i < 9; i++) add(0, 1, 3, 1, 0);
        add(0, 1, 3, 1, 1);
`ifdef LED_PATTERN_BREATHE_EN
        add(0, 1, 2, 0, 0);
`else
        add(0, 1, 2, 1, 0);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; en = tbl[i].e; mode = tbl[i].md;
            cyc(0);
            check($sformatf("tbl_led[%0d]", i), 32'(led), 32'(tbl[i].led));
            check($sformatf("tbl_tick[%0d]", i), 32'(tick), 32'(tbl[i].tk));
        end

        // COUNT: 64 steps at 10-clock spacing, wrapping to 0.
        rst = 1'b1; en = 1'b0; cyc(0); cyc(0);
        rst = 1'b0; mode = 2'b00; en = 1'b1;
        cyc(0);
        check("count_entry", 32'(led), 32'(0));
        for (int i = 1; i <= 64; i++) begin
            wait_tick(20, n);
            check("count_interval", 32'(n), 32'(10));
            check("count_led", 32'(led), 32'(i % 64));
        end

        // Enable freeze mid-prescaler, then the remaining count completes.
        for (int i = 0; i < 5; i++) wait_tick(20, n);
        check("en_start", 32'(led), 32'(5));
        cyc(0); cyc(0); cyc(0);
        en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            cyc(0);
            check("en_off_led", 32'(led), 32'(5));
            check("en_off_tick", 32'(tick), 32'(0));
        end
        en = 1'b1;
        wait_tick(20, n);
        check("en_resume_interval", 32'(n), 32'(7));
        check("en_resume_led", 32'(led), 32'(6));

        // Mode switch to SHIFT: immediate entry, full period to first step.
        mode = 2'b01;
        cyc(0);
        check("sw_led", 32'(led), 32'(1));
        check("sw_tick", 32'(tick), 32'(0));
        wait_tick(20, n);
        check("sw_interval", 32'(n), 32'(10));
        check("sw_led_step1", 32'(led), 32'(2));
        for (int j = 2; j < 22; j++) begin
            wait_tick(20, n);
            check("shift_led", 32'(led), 32'(sh[j % 10]));
        end

        // Reset in the middle of SHIFT at led=001000.
        n = 0;
        while (led != 6'b001000 && n < 12) begin
            wait_tick(20, ones);
            n++;
        end
        check("shift_reach_8", 32'(led), 32'(8));
        rst = 1'b1;
        cyc(0);
        check("midrst_led", 32'(led), 32'(0));
        check("midrst_tick", 32'(tick), 32'(0));
        rst = 1'b0;
        cyc(0);
        check("midrst_reentry", 32'(led), 32'(1));

        // BREATHE: 3 steps from entry give duty 3 (3 of 8 clocks lit).
        mode = 2'b00;
        cyc(0);
        for (int i = 0; i < 3; i++) wait_tick(20, n);
        check("br_pre_led", 32'(led), 32'(3));
        held = led;
        mode = 2'b10;
        cyc(0);
`ifdef LED_PATTERN_BREATHE_EN
        check("br_entry_led", 32'(led), 32'(0));
`else
        check("br_entry_led", 32'(led), 32'(held));
`endif
        for (int i = 0; i < 3; i++) wait_tick(20, n);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0);
`ifdef LED_PATTERN_BREATHE_EN
            check("br_led_level", 32'((led == 6'h3f || led == 6'h00) ? 1 : 0), 32'(1));
            if (led == 6'h3f) ones++;
`else
            check("br_frozen_led", 32'(led), 32'(held));
`endif
        end
`ifdef LED_PATTERN_BREATHE_EN
        check("br_ones", 32'(ones), 32'(3));
`endif

        // Randomized run against the reference model.
        rst = 1'b1; en = 1'b1;
        cyc(0);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
